// File: rtl/sram_ctrl_pkg.sv
// Shared constants, state encoding and sizing helper for the sram_ctrl slice.
// The INIT state is only entered when SRAM_CTRL_INIT_EN is defined.
package sram_ctrl_pkg;

   localparam int DEF_WIDTH     = 8;
   localparam int DEF_DEPTH     = 8;
   localparam int DEF_LEN_WIDTH = 3;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_WRITE = 3'd1;
   localparam state_t ST_READ  = 3'd2;
   localparam state_t ST_DRAIN = 3'd3;
   localparam state_t ST_INIT  = 3'd4;

   // The counter must cover both a full burst and a full memory sweep.
   function automatic int beat_cnt_width(input int len_width, input int depth);
      int dw;
      dw = (depth > 1) ? $clog2(depth) : 1;
      return (len_width > dw) ? len_width : dw;
   endfunction

endpackage

// File: rtl/sram_ctrl_addr_gen.sv
// Address walker shared by burst reads and the memory clear sweep:
// loadable start address, increment modulo DEPTH, beat countdown with last flag.
module sram_ctrl_addr_gen
   import sram_ctrl_pkg::*;
#(
   parameter int DEPTH      = DEF_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int CNT_WIDTH  = beat_cnt_width(DEF_LEN_WIDTH, DEPTH),
   parameter int RST_COUNT  = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [CNT_WIDTH-1:0]  beats_m1,
   input  logic                  step,
   output logic [ADDR_WIDTH-1:0] next_addr,
   output logic                  last
);

   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [CNT_WIDTH-1:0]  cnt_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_reg <= '0;
         cnt_reg  <= CNT_WIDTH'(RST_COUNT);
      end else if (load) begin
         addr_reg <= start_addr;
         cnt_reg  <= beats_m1;
      end else if (step) begin
         addr_reg <= next_addr;
         cnt_reg  <= cnt_reg - 1'b1;
      end
   end

   assign next_addr = (addr_reg == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_reg + 1'b1;
   assign last      = (cnt_reg == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Single-port SRAM host controller: single-beat writes, burst reads with a
// two-cycle return pipeline. Define SRAM_CTRL_INIT_EN to zero the memory after reset.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0]      req_wdata,
   input  logic [LEN_WIDTH-1:0]  req_len,
   output logic                  rsp_valid,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  rsp_last,
   output logic                  wr_ack,
   output logic                  init_busy,
   output logic                  sram_chip_sel,
   output logic                  sram_read_ena,
   output logic                  sram_write_ena,
   output logic [ADDR_WIDTH-1:0] sram_address,
   output logic [WIDTH-1:0]      sram_data_in,
   input  logic [WIDTH-1:0]      sram_data_out
);

   localparam int CNT_WIDTH = beat_cnt_width(LEN_WIDTH, DEPTH);

`ifdef SRAM_CTRL_INIT_EN
   // Reset lands directly in the clear sweep with address 0 already on the pins.
   localparam state_t RST_STATE = ST_INIT;
   localparam logic   RST_PINS  = 1'b1;
   localparam int     RST_COUNT = DEPTH - 1;
`else
   localparam state_t RST_STATE = ST_IDLE;
   localparam logic   RST_PINS  = 1'b0;
   localparam int     RST_COUNT = 0;
`endif

   state_t                state_reg;
   logic                  chip_sel_reg, read_ena_reg, write_ena_reg;
   logic [ADDR_WIDTH-1:0] address_reg;
   logic [WIDTH-1:0]      data_in_reg;
   logic                  rd_pipe_reg, last_pipe_reg;
   logic                  rsp_valid_reg, rsp_last_reg, wr_ack_reg;
   logic [WIDTH-1:0]      rsp_data_reg;

   logic                  gen_load, gen_step, gen_last;
   logic [ADDR_WIDTH-1:0] gen_next_addr;

   assign req_ready = (state_reg == ST_IDLE);
   assign gen_load  = req_ready && req_valid && !req_write;
   assign gen_step  = ((state_reg == ST_READ) || (state_reg == ST_INIT)) && !gen_last;

   sram_ctrl_addr_gen #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH),
      .RST_COUNT  (RST_COUNT)
   ) u_addr_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (gen_load),
      .start_addr (req_addr),
      .beats_m1   (CNT_WIDTH'(req_len)),
      .step       (gen_step),
      .next_addr  (gen_next_addr),
      .last       (gen_last)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= RST_STATE;
         chip_sel_reg  <= RST_PINS;
         write_ena_reg <= RST_PINS;
         read_ena_reg  <= 1'b0;
         address_reg   <= '0;
         data_in_reg   <= '0;
         rd_pipe_reg   <= 1'b0;
         last_pipe_reg <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_last_reg  <= 1'b0;
         rsp_data_reg  <= '0;
         wr_ack_reg    <= 1'b0;
      end else begin
         // Return pipeline: SRAM registers data one edge after the pins, we capture one later.
         rd_pipe_reg   <= read_ena_reg;
         last_pipe_reg <= (state_reg == ST_READ) && gen_last;
         rsp_valid_reg <= rd_pipe_reg;
         rsp_last_reg  <= last_pipe_reg;
         if (rd_pipe_reg) rsp_data_reg <= sram_data_out;
         wr_ack_reg    <= 1'b0;

         case (state_reg)
            ST_IDLE: begin
               if (req_valid) begin
                  chip_sel_reg  <= 1'b1;
                  address_reg   <= req_addr;
                  write_ena_reg <= req_write;
                  read_ena_reg  <= !req_write;
                  data_in_reg   <= req_write ? req_wdata : '0;
                  state_reg     <= req_write ? ST_WRITE : ST_READ;
               end
            end
            ST_WRITE: begin
               chip_sel_reg  <= 1'b0;
               write_ena_reg <= 1'b0;
               address_reg   <= '0;
               data_in_reg   <= '0;
               wr_ack_reg    <= 1'b1;
               state_reg     <= ST_IDLE;
            end
            ST_READ: begin
               if (gen_last) begin
                  chip_sel_reg <= 1'b0;
                  read_ena_reg <= 1'b0;
                  address_reg  <= '0;
                  state_reg    <= ST_DRAIN;
               end else begin
                  address_reg  <= gen_next_addr;
               end
            end
            ST_DRAIN: state_reg <= ST_IDLE;
`ifdef SRAM_CTRL_INIT_EN
            ST_INIT: begin
               if (gen_last) begin
                  chip_sel_reg  <= 1'b0;
                  write_ena_reg <= 1'b0;
                  address_reg   <= '0;
                  state_reg     <= ST_IDLE;
               end else begin
                  address_reg   <= gen_next_addr;
               end
            end
`endif
            default: begin
               chip_sel_reg  <= 1'b0;
               read_ena_reg  <= 1'b0;
               write_ena_reg <= 1'b0;
               address_reg   <= '0;
               data_in_reg   <= '0;
               state_reg     <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef SRAM_CTRL_INIT_EN
   assign init_busy = (state_reg == ST_INIT);
`else
   assign init_busy = 1'b0;
`endif

   assign sram_chip_sel  = chip_sel_reg;
   assign sram_read_ena  = read_ena_reg;
   assign sram_write_ena = write_ena_reg;
   assign sram_address   = address_reg;
   assign sram_data_in   = data_in_reg;
   assign rsp_valid      = rsp_valid_reg;
   assign rsp_last       = rsp_last_reg;
   assign rsp_data       = rsp_data_reg;
   assign wr_ack         = wr_ack_reg;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl with a behavioural single-port SRAM and a word-array reference.
// Directed scenarios followed by randomized writes/bursts; SRAM_CTRL_INIT_EN adds the clear test.
module tb_sram_ctrl;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int LW    = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [WIDTH-1:0] req_wdata = '0;
   logic [LW-1:0] req_len = '0;
   logic          req_ready, rsp_valid, rsp_last, wr_ack, init_busy;
   logic [WIDTH-1:0] rsp_data, sram_data_in;
   logic [WIDTH-1:0] sram_data_out = '0;
   logic          sram_chip_sel, sram_read_ena, sram_write_ena;
   logic [AW-1:0] sram_address;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] ref_mem [DEPTH];

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sram_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_len        (req_len),
      .rsp_valid      (rsp_valid),
      .rsp_data       (rsp_data),
      .rsp_last       (rsp_last),
      .wr_ack         (wr_ack),
      .init_busy      (init_busy),
      .sram_chip_sel  (sram_chip_sel),
      .sram_read_ena  (sram_read_ena),
      .sram_write_ena (sram_write_ena),
      .sram_address   (sram_address),
      .sram_data_in   (sram_data_in),
      .sram_data_out  (sram_data_out)
   );

   // Single-port SRAM: synchronous write, registered read.
   always @(posedge clk) begin
      if (sram_chip_sel && sram_write_ena) mem[sram_address] <= sram_data_in;
      if (sram_chip_sel && sram_read_ena)  sram_data_out <= mem[sram_address];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_excl();
      chk("rd_wr_excl", 32'(sram_read_ena & sram_write_ena), 32'd0);
   endtask

   task automatic wait_ready();
      int g = 0;
      while (!req_ready && g < 200) begin
         @(negedge clk);
         g++;
      end
      chk("ready_timeout", 32'(g < 200), 32'd1);
   endtask

   task automatic apply_reset(input int hold);
      rst_n = 1'b0;
      req_valid = 1'b0;
      repeat (hold) @(posedge clk);
      @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_last", 32'(rsp_last), 32'd0);
      chk("rst_wr_ack", 32'(wr_ack), 32'd0);
      chk("rst_read_ena", 32'(sram_read_ena), 32'd0);
`ifdef SRAM_CTRL_INIT_EN
      begin
         int b = 1;
         chk("rst_init_busy", 32'(init_busy), 32'd1);
         chk("rst_ready", 32'(req_ready), 32'd0);
         chk("rst_init_addr", 32'(sram_address), 32'd0);
         rst_n = 1'b1;
         forever begin
            @(negedge clk);
            chk_excl();
            if (!init_busy || b >= 100) break;
            b++;
         end
         chk("init_busy_cycles", 32'(b), 32'(DEPTH));
         chk("init_ready", 32'(req_ready), 32'd1);
         for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end
`else
      chk("rst_init_busy", 32'(init_busy), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_chip_sel", 32'(sram_chip_sel), 32'd0);
      chk("rst_write_ena", 32'(sram_write_ena), 32'd0);
      chk("rst_address", 32'(sram_address), 32'd0);
      chk("rst_data_in", 32'(sram_data_in), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(req_ready), 32'd1);
      chk("post_rst_valid", 32'(rsp_valid), 32'd0);
`endif
      $display("reset hold=%0d", hold);
   endtask

   task automatic do_write(input int a, input logic [WIDTH-1:0] d);
      wait_ready();
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = AW'(a);
      req_wdata = d;
      req_len   = LW'($urandom);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("wr_chip_sel", 32'(sram_chip_sel), 32'd1);
      chk("wr_write_ena", 32'(sram_write_ena), 32'd1);
      chk("wr_read_ena", 32'(sram_read_ena), 32'd0);
      chk("wr_address", 32'(sram_address), 32'(a));
      chk("wr_data_in", 32'(sram_data_in), 32'(d));
      chk("wr_ack_early", 32'(wr_ack), 32'd0);
      chk("wr_ready_low", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("wr_ack", 32'(wr_ack), 32'd1);
      chk("wr_ready_back", 32'(req_ready), 32'd1);
      chk("wr_pins_idle", 32'(sram_chip_sel | sram_write_ena), 32'd0);
      ref_mem[a] = d;
      $display("write addr=%0d data=%02h", a, d);
   endtask

   task automatic do_read(input int a, input int len);
      int n = len + 1;
      logic [WIDTH-1:0] last_d;
      wait_ready();
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = AW'(a);
      req_len   = LW'(len);
      req_wdata = WIDTH'($urandom);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int j = 0; j <= n + 1; j++) begin
         if (j > 0) @(negedge clk);
         chk_excl();
         chk("rd_read_ena", 32'(sram_read_ena), 32'(j < n));
         chk("rd_chip_sel", 32'(sram_chip_sel), 32'(j < n));
         chk("rd_address", 32'(sram_address), (j < n) ? 32'((a + j) % DEPTH) : 32'd0);
         chk("rd_ready", 32'(req_ready), 32'(j == n + 1));
         chk("rd_rsp_valid", 32'(rsp_valid), 32'(j >= 2));
         if (j >= 2) begin
            chk("rd_rsp_data", 32'(rsp_data), 32'(ref_mem[(a + j - 2) % DEPTH]));
            chk("rd_rsp_last", 32'(rsp_last), 32'(j == n + 1));
         end
      end
      last_d = ref_mem[(a + len) % DEPTH];
      @(negedge clk);
      chk("rd_valid_after", 32'(rsp_valid), 32'd0);
      chk("rd_data_hold", 32'(rsp_data), 32'(last_d));
      $display("read addr=%0d len=%0d last=%02h", a, len, last_d);
   endtask

   initial begin
      apply_reset(2);

      // Write then immediately read back the same word.
      do_write(4, 8'hAA);
      do_read(4, 0);

      // Burst wrapping DEPTH-1 -> 0.
      do_write(7, 8'h11);
      do_write(0, 8'h22);
      do_read(7, 1);

      // Full-depth burst across the wrap.
      for (int a = 0; a < DEPTH; a++) do_write(a, WIDTH'(a + 'h30));
      do_read(2, 7);

      // Write held pending while a burst owns the controller.
      begin
         int j = 0;
         wait_ready();
         req_valid = 1'b1;
         req_write = 1'b0;
         req_addr  = 3'd0;
         req_len   = 3'd7;
         @(posedge clk);
         @(negedge clk);
         req_write = 1'b1;
         req_addr  = 3'd3;
         req_wdata = 8'h5A;
         while (!req_ready && j < 50) begin
            chk("hold_no_write", 32'(sram_write_ena), 32'd0);
            chk_excl();
            @(negedge clk);
            j++;
         end
         chk("hold_ready_cycle", 32'(j), 32'd9);
         chk("hold_last_with_ready", 32'(rsp_last), 32'd1);
         @(posedge clk);
         @(negedge clk);
         req_valid = 1'b0;
         chk("hold_wr_pins", 32'({sram_chip_sel, sram_write_ena}), 32'd3);
         chk("hold_wr_addr", 32'(sram_address), 32'd3);
         chk("hold_wr_data", 32'(sram_data_in), 32'h5A);
         @(negedge clk);
         chk("hold_wr_ack", 32'(wr_ack), 32'd1);
         ref_mem[3] = 8'h5A;
         $display("held write addr=3 data=5a");
         do_read(3, 0);
      end

      // Reset during the third beat of a len-7 burst.
      begin
         wait_ready();
         req_valid = 1'b1;
         req_write = 1'b0;
         req_addr  = 3'd0;
         req_len   = 3'd7;
         @(posedge clk);
         @(negedge clk);
         req_valid = 1'b0;
         repeat (4) @(negedge clk);
         chk("mid_beat2_valid", 32'(rsp_valid), 32'd1);
         chk("mid_beat2_data", 32'(rsp_data), 32'(ref_mem[2]));
         apply_reset(1);
         repeat (3) begin
            @(negedge clk);
            chk("mid_no_valid", 32'(rsp_valid), 32'd0);
            chk("mid_no_read", 32'(sram_read_ena), 32'd0);
         end
         $display("mid-burst reset done");
      end

`ifdef SRAM_CTRL_INIT_EN
      do_write(5, 8'hFF);
      apply_reset(1);
      do_read(5, 0);
`endif

      // Randomized traffic.
      repeat (60) begin
         if ($urandom_range(0, 1) == 1)
            do_write($urandom_range(0, DEPTH - 1), WIDTH'($urandom));
         else
            do_read($urandom_range(0, DEPTH - 1), $urandom_range(0, 7));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
